// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: multi-cycle controller for the ALU operand-select muxes.
// Each instruction class is stepped through one or two single-cycle ALU
// passes. All outputs are a Moore decode of the state register and the
// class/branch-outcome latched alongside it.
// Optional feature macro: ALU_SEQ_PERF_EN (retired-instruction and
// extra-pass performance counters; tied to zero when undefined).
//
// Handshake: an instruction transfers on a rising edge where
// instr_valid & instr_ready & !flush; instr_ready is high only in IDLE.
// The first ALU pass occupies the following cycle.
module alu_op_sequencer #(
  parameter int CNT_W        = 32,
  parameter bit JALR_LSB_CLR = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [2:0]       op_class,
  input  logic [2:0]       funct3,
  input  logic             flush,
  input  logic             alu_zero,
  input  logic             alu_lt,
  input  logic             alu_ltu,
  output logic             ALUSrc2,
  output logic             ALUSrc,
  output logic             four_sel,
  output logic             cmp_sub,
  output logic             clr_lsb,
  output logic             rd_we,
  output logic             pc_we,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] perf_instr,
  output logic [CNT_W-1:0] perf_stall
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_LINK = 3'd2,
    S_TGT  = 3'd3,
    S_CMP  = 3'd4,
    S_BRX  = 3'd5,
    S_ILL  = 3'd6
  } state_t;

  localparam logic [2:0] CLS_RR     = 3'b000;
  localparam logic [2:0] CLS_RI     = 3'b001;
  localparam logic [2:0] CLS_AUIPC  = 3'b010;
  localparam logic [2:0] CLS_JAL    = 3'b011;
  localparam logic [2:0] CLS_JALR   = 3'b100;
  localparam logic [2:0] CLS_BRANCH = 3'b101;

  state_t     state_q, state_d;
  logic [2:0] cls_q, cls_d;
  logic [2:0] f3_q, f3_d;
  logic       taken_q, taken_d;
  logic       cmp_taken;

  // Branch condition from the ALU flags, using the funct3 latched at accept.
  always_comb begin
    cmp_taken = 1'b0;
    case (f3_q)
      3'b000:  cmp_taken = alu_zero;
      3'b001:  cmp_taken = ~alu_zero;
      3'b100:  cmp_taken = alu_lt;
      3'b101:  cmp_taken = ~alu_lt;
      3'b110:  cmp_taken = alu_ltu;
      3'b111:  cmp_taken = ~alu_ltu;
      default: cmp_taken = 1'b0;
    endcase
  end

  // Next-state, instruction latching and branch-outcome capture.
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    f3_d    = f3_q;
    taken_d = taken_q;
    if (state_q == S_CMP) begin
      taken_d = cmp_taken;
    end
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (instr_valid) begin
            cls_d = op_class;
            f3_d  = funct3;
            case (op_class)
              CLS_RR, CLS_RI, CLS_AUIPC: state_d = S_EXEC;
              CLS_JAL, CLS_JALR:         state_d = S_LINK;
              CLS_BRANCH:                state_d = S_CMP;
              default:                   state_d = S_ILL;
            endcase
          end
        end
        S_LINK:  state_d = S_TGT;
        S_CMP:   state_d = S_BRX;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and latched-instruction registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cls_q   <= 3'b000;
      f3_q    <= 3'b000;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      f3_q    <= f3_d;
      taken_q <= taken_d;
    end
  end

  // Moore output decode per pass.
  always_comb begin
    instr_ready = (state_q == S_IDLE);
    busy        = (state_q != S_IDLE);
    ALUSrc2     = 1'b0;
    ALUSrc      = 1'b0;
    four_sel    = 1'b0;
    cmp_sub     = 1'b0;
    clr_lsb     = 1'b0;
    rd_we       = 1'b0;
    pc_we       = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      S_EXEC: begin
        rd_we = 1'b1;
        done  = 1'b1;
        case (cls_q)
          CLS_RI:    ALUSrc = 1'b1;
          CLS_AUIPC: begin
            ALUSrc2 = 1'b1;
            ALUSrc  = 1'b1;
          end
          default:   ;
        endcase
      end
      S_LINK: begin
        ALUSrc2  = 1'b1;
        four_sel = 1'b1;
        rd_we    = 1'b1;
      end
      S_TGT: begin
        ALUSrc = 1'b1;
        pc_we  = 1'b1;
        done   = 1'b1;
        if (cls_q == CLS_JALR) begin
          clr_lsb = JALR_LSB_CLR;
        end else begin
          ALUSrc2 = 1'b1;
        end
      end
      S_CMP: begin
        cmp_sub = 1'b1;
      end
      S_BRX: begin
        ALUSrc2 = 1'b1;
        pc_we   = 1'b1;
        done    = 1'b1;
        if (taken_q) begin
          ALUSrc = 1'b1;
        end else begin
          four_sel = 1'b1;
        end
      end
      S_ILL: begin
        illegal = 1'b1;
        done    = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef ALU_SEQ_PERF_EN
  logic [CNT_W-1:0] perf_instr_q, perf_instr_d;
  logic [CNT_W-1:0] perf_stall_q, perf_stall_d;

  // Counter updates: retire on every done pulse, stall on every extra pass.
  always_comb begin
    perf_instr_d = perf_instr_q;
    perf_stall_d = perf_stall_q;
    if (done) begin
      perf_instr_d = perf_instr_q + 1'b1;
    end
    if (state_q == S_LINK || state_q == S_CMP) begin
      perf_stall_d = perf_stall_q + 1'b1;
    end
  end

  // Counter registers; only reset clears them, flush leaves them alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_instr_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_instr_q <= perf_instr_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_instr = perf_instr_q;
  assign perf_stall = perf_stall_q;
`else
  assign perf_instr = '0;
  assign perf_stall = '0;
`endif

endmodule
